// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encoding shared by the pipelined barrel shifter and its stages.
package shifter_pkg;

    typedef logic [2:0] sh_mode_t;

    localparam sh_mode_t SH_PASS = 3'b000;
    localparam sh_mode_t SH_SLL  = 3'b001;
    localparam sh_mode_t SH_SRL  = 3'b010;
    localparam sh_mode_t SH_SRA  = 3'b011;
    localparam sh_mode_t SH_ROL  = 3'b100;
    localparam sh_mode_t SH_ROR  = 3'b101;
    // 3'b110 and 3'b111 are treated as pass.

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: combinational shift/rotate by 2^K for one pipeline stage.
// With SHIFTER_FLAGS_EN defined it also picks the last bit moved out
// (carry); otherwise the carry path does not exist.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] d_i,
    input  sh_mode_t         mode_i,
    input  logic             en_i,      // amt bit K of this operation
    input  logic             sign_i,    // original operand MSB, used for SRA fill
`ifdef SHIFTER_FLAGS_EN
    input  logic             carry_i,
    output logic             carry_o,
`endif
    output logic [WIDTH-1:0] d_o
);

    localparam int S = 1 << K;

    // Shift or rotate by S when enabled, otherwise pass through.
    always_comb begin
        d_o = d_i;
        if (en_i) begin
            case (mode_i)
                SH_SLL:  d_o = d_i << S;
                SH_SRL:  d_o = d_i >> S;
                SH_SRA:  d_o = {{S{sign_i}}, d_i[WIDTH-1:S]};
                SH_ROL:  d_o = {d_i[WIDTH-S-1:0], d_i[WIDTH-1:WIDTH-S]};
                SH_ROR:  d_o = {d_i[S-1:0], d_i[WIDTH-1:S]};
                default: d_o = d_i;
            endcase
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Last bit leaving the word: for left moves it is bit WIDTH-S, for right
    // moves bit S-1. Stages apply amounts in increasing order, so the highest
    // active stage decides the final carry; inactive stages keep it.
    always_comb begin
        carry_o = carry_i;
        if (en_i) begin
            case (mode_i)
                SH_SLL, SH_ROL:         carry_o = d_i[WIDTH-S];
                SH_SRL, SH_SRA, SH_ROR: carry_o = d_i[S-1];
                default:                carry_o = carry_i;
            endcase
        end
    end
`endif

endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: AW-stage pipelined barrel shifter with valid/ready flow control.
// Stage k shifts by 2^k when amt[k] is set. All stages advance together when
// the output slot is free or being drained, so bubbles are never squeezed out.
// Optional flags (carry, zero) are built when SHIFTER_FLAGS_EN is defined.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  sh_mode_t         sh,
    input  logic [AW-1:0]    amt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFTER_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic [WIDTH-1:0] out
);

    // Stage registers; index k holds the result after stage k.
    logic     [AW-1:0][WIDTH-1:0] data_q;
    logic     [AW-1:0]            vld_q;
    logic     [AW-1:0]            sign_q;
    sh_mode_t [AW-1:0]            mode_q;
    logic     [AW-1:0][AW-1:0]    amt_q;

    // Stage inputs: stage 0 takes the ports, stage k takes register k-1.
    logic     [AW-1:0][WIDTH-1:0] data_nx;
    logic     [AW-1:0]            vld_nx;
    logic     [AW-1:0]            sign_nx;
    sh_mode_t [AW-1:0]            mode_nx;
    logic     [AW-1:0][AW-1:0]    amt_nx;

    logic     [WIDTH-1:0]         data_d [AW];
    logic                         adv;

    assign data_nx = {data_q[AW-2:0], in};
    assign vld_nx  = {vld_q[AW-2:0],  in_valid};
    assign sign_nx = {sign_q[AW-2:0], in[WIDTH-1]};
    assign mode_nx = {mode_q[AW-2:0], sh};
    assign amt_nx  = {amt_q[AW-2:0],  amt};

    assign adv       = !vld_q[AW-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[AW-1];
    assign out       = data_q[AW-1];

    // Last stage's control fields and the lower amt bits of later stages
    // have no reader; fold them here so the intent is explicit.
    logic unused_ctrl;
    assign unused_ctrl = ^{mode_q[AW-1], amt_q, sign_q[AW-1]};

`ifdef SHIFTER_FLAGS_EN
    logic [AW-1:0] carry_q;
    logic [AW-1:0] carry_nx;
    logic [AW-1:0] carry_d;
    logic          zero_q;

    assign carry_nx = {carry_q[AW-2:0], 1'b0};
    assign carry    = carry_q[AW-1];
    assign zero     = zero_q;
`endif

    for (genvar k = 0; k < AW; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .d_i     (data_nx[k]),
            .mode_i  (mode_nx[k]),
            .en_i    (amt_nx[k][k]),
            .sign_i  (sign_nx[k]),
`ifdef SHIFTER_FLAGS_EN
            .carry_i (carry_nx[k]),
            .carry_o (carry_d[k]),
`endif
            .d_o     (data_d[k])
        );
    end

    // Advance every stage together; reset clears all in-flight state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
            sign_q <= '0;
            mode_q <= '0;
            amt_q  <= '0;
        end else if (adv) begin
            for (int k = 0; k < AW; k++) data_q[k] <= data_d[k];
            vld_q  <= vld_nx;
            sign_q <= sign_nx;
            mode_q <= mode_nx;
            amt_q  <= amt_nx;
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Carry chain and the zero flag travel with the data; zero is only
    // raised for a real result, never for a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= '0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            carry_q <= carry_d;
            zero_q  <= vld_nx[AW-1] && (data_d[AW-1] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed vectors with hand-computed results for shifter_pipe
// (WIDTH=32). Flag checks are compiled when SHIFTER_FLAGS_EN is defined.
module tb_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_d;
    logic [2:0]  sh_d;
    logic [4:0]  amt_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
`ifdef SHIFTER_FLAGS_EN
    logic        carry_o;
    logic        zero_o;
`endif

    always #5 clk = ~clk;

    shifter_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_d),
        .sh        (sh_d),
        .amt       (amt_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFTER_FLAGS_EN
        .carry     (carry_o),
        .zero      (zero_o),
`endif
        .out       (out_q)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] o;
        logic        c;
        logic        z;
        int          cyc;
        logic        lat;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  m;
        logic [4:0]  a;
        logic [31:0] eo;
        logic        ec;
        logic        ez;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t tv[$];

    // Scoreboard: accepts push the expected result, consumes pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out", out_q, e.o);
`ifdef SHIFTER_FLAGS_EN
                    chk("carry", 32'(carry_o), 32'(e.c));
                    chk("zero", 32'(zero_o), 32'(e.z));
`endif
                    if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd5);
                end
            end
            if (in_valid && in_ready) begin
                e = cur;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] m, input logic [4:0] a,
                        input logic [31:0] eo, input logic ec, input logic ez, input logic lat);
        logic acc;
        logic ok;
        ok = 1'b0;
        in_d = d; sh_d = m; amt_d = a; in_valid = 1'b1;
        cur.o = eo; cur.c = ec; cur.z = ez; cur.cyc = 0; cur.lat = lat;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_d = '0; sh_d = '0; amt_d = '0;
        cur = '{32'h0, 1'b0, 1'b0, 0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out_q, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_FLAGS_EN
        chk("rst_carry", 32'(carry_o), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
`endif
        rst_n = 1'b1;

        // Modes on 0xF by 4, sign fill, edge amounts, pass codes.
        tv.push_back('{32'h0000000F, 3'd0, 5'd4,  32'h0000000F, 1'b0, 1'b0});
        tv.push_back('{32'h0000000F, 3'd1, 5'd4,  32'h000000F0, 1'b0, 1'b0});
        tv.push_back('{32'h0000000F, 3'd2, 5'd4,  32'h00000000, 1'b1, 1'b1});
        tv.push_back('{32'h0000000F, 3'd3, 5'd4,  32'h00000000, 1'b1, 1'b1});
        tv.push_back('{32'h0000000F, 3'd4, 5'd4,  32'h000000F0, 1'b0, 1'b0});
        tv.push_back('{32'h0000000F, 3'd5, 5'd4,  32'hF0000000, 1'b1, 1'b0});
        tv.push_back('{32'hF0000000, 3'd3, 5'd4,  32'hFF000000, 1'b0, 1'b0});
        tv.push_back('{32'hF0000000, 3'd2, 5'd4,  32'h0F000000, 1'b0, 1'b0});
        tv.push_back('{32'hF0000000, 3'd3, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0});
        tv.push_back('{32'hF0000000, 3'd4, 5'd1,  32'hE0000001, 1'b1, 1'b0});
        tv.push_back('{32'h80000001, 3'd1, 5'd1,  32'h00000002, 1'b1, 1'b0});
        tv.push_back('{32'h00000001, 3'd1, 5'd31, 32'h80000000, 1'b0, 1'b0});
        tv.push_back('{32'h80000000, 3'd2, 5'd31, 32'h00000001, 1'b0, 1'b0});
        tv.push_back('{32'h80000001, 3'd5, 5'd31, 32'h00000003, 1'b0, 1'b0});
        for (int m = 0; m < 8; m++)
            tv.push_back('{32'hA5A55A5A, 3'(m), 5'd0, 32'hA5A55A5A, 1'b0, 1'b0});
        tv.push_back('{32'h12345678, 3'd6, 5'd4,  32'h12345678, 1'b0, 1'b0});
        tv.push_back('{32'h12345678, 3'd7, 5'd4,  32'h12345678, 1'b0, 1'b0});
        foreach (tv[i]) send(tv[i].d, tv[i].m, tv[i].a, tv[i].eo, tv[i].ec, tv[i].ez, 1'b1);
        idle(1);
        drain();

        // Backpressure: 8 x (3 << k), output stalled for 4 cycles.
        fork
            begin
                for (int k = 1; k <= 8; k++)
                    send(32'h3, 3'd1, 5'(k), 32'h3 << k, 1'b0, 1'b0, 1'b0);
                idle(1);
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_out_hold", out_q, 32'h00000018);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Bubbles: alternate cycles, each result exactly 5 cycles after accept.
        for (int k = 1; k <= 4; k++) begin
            send(32'h1, 3'd5, 5'(k), 32'h80000000 >> (k - 1), 1'b1 && (k == 1), 1'b0, 1'b1);
            idle(1);
        end
        drain();

        // Reset with three ops in flight plus one presented during reset.
        send(32'h11111111, 3'd1, 5'd1, 32'h22222222, 1'b0, 1'b0, 1'b1);
        send(32'h22222222, 3'd1, 5'd1, 32'h44444444, 1'b0, 1'b0, 1'b1);
        send(32'h44444444, 3'd1, 5'd1, 32'h88888888, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        in_valid = 1'b1; in_d = 32'hDEADBEEF; sh_d = 3'd0; amt_d = 5'd0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", out_q, 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        idle(12);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
